// File: rtl/gpu_stencil_bank_array.sv
// Banked stencil RAM: NBANK dual-port banks, one read port with write-to-read bypass,
// a masked write port (partial masks go read-modify-write), and a full-array fill engine.
module gpu_stencil_bank_array #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int BANK_BITS = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_ready_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_mask_i,
    input  logic [DATA_W-1:0] wr_value_i,
    output logic              wr_ready_o,
    input  logic              clr_req_i,
    input  logic [DATA_W-1:0] clr_value_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    input  logic              err_clr_i,
    output logic              err_o
);
    localparam int NBANK = 1 << BANK_BITS;
    localparam int ROW_W = ADDR_W - BANK_BITS;
    localparam int ROWS  = 1 << ROW_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]        state_q;
    logic [ROW_W-1:0]  fill_row_q;
    logic [DATA_W-1:0] fill_value_q;
    logic              rmw_pending_q;
    logic [ADDR_W-1:0] rmw_addr_q;
    logic [DATA_W-1:0] rmw_value_q;
    logic [DATA_W-1:0] rmw_mask_q;
    logic              rd_valid_q;
    logic              err_q;
    logic              rd_bypass_q;
    logic [DATA_W-1:0] rd_bypass_data_q;
    logic [BANK_BITS-1:0] rd_bank_q;

    logic is_idle, fill_active, fill_last;
    logic rd_acc, wr_acc, wr_full, full_wr, part_wr, clr_acc, err_set;
    logic [BANK_BITS-1:0] rd_bank, wr_bank, commit_bank;
    logic [ROW_W-1:0]     rd_row, wr_row, commit_row;
    logic                 commit_en;
    logic [ADDR_W-1:0]    commit_addr;
    logic [DATA_W-1:0]    commit_data, rmw_old, rmw_merged;
    logic [DATA_W-1:0]    bank_rd  [NBANK];
    logic [DATA_W-1:0]    bank_old [NBANK];

    assign is_idle     = (state_q == ST_IDLE);
    assign fill_active = (state_q == ST_FILL);
    assign fill_last   = fill_active & (&fill_row_q);

    assign rd_ready_o = is_idle;
    assign wr_ready_o = is_idle & ~rmw_pending_q & ~clr_req_i;
    assign clr_busy_o = fill_active;
    assign clr_done_o = fill_last;
    assign err_o      = err_q;
    assign rd_valid_o = rd_valid_q;

    assign rd_acc  = rd_req_i & rd_ready_o;
    assign wr_acc  = wr_req_i & wr_ready_o;
    assign wr_full = &wr_mask_i;
    assign full_wr = wr_acc & wr_full;
    assign part_wr = wr_acc & ~wr_full;
    assign clr_acc = clr_req_i & is_idle;
    assign err_set = (wr_req_i & ~wr_ready_o) | (rd_req_i & ~rd_ready_o);

    assign rd_bank = rd_addr_i[BANK_BITS-1:0];
    assign rd_row  = rd_addr_i[ADDR_W-1:BANK_BITS];
    assign wr_bank = wr_addr_i[BANK_BITS-1:0];
    assign wr_row  = wr_addr_i[ADDR_W-1:BANK_BITS];

    // A pending RMW commit and an accepted full write can never coincide, and neither
    // can happen during a fill, so port A sees at most one non-fill commit per cycle.
    assign rmw_old     = bank_old[rmw_addr_q[BANK_BITS-1:0]];
    assign rmw_merged  = (rmw_value_q & rmw_mask_q) | (rmw_old & ~rmw_mask_q);
    assign commit_en   = rmw_pending_q | full_wr;
    assign commit_addr = rmw_pending_q ? rmw_addr_q : wr_addr_i;
    assign commit_data = rmw_pending_q ? rmw_merged : wr_value_i;
    assign commit_bank = commit_addr[BANK_BITS-1:0];
    assign commit_row  = commit_addr[ADDR_W-1:BANK_BITS];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] rd_q;
        logic [DATA_W-1:0] old_q;
        logic              bank_we;
        logic [ROW_W-1:0]  bank_row;
        logic [DATA_W-1:0] bank_data;

        assign bank_we   = fill_active | (commit_en & (commit_bank == BANK_BITS'(b)));
        assign bank_row  = fill_active ? fill_row_q : commit_row;
        assign bank_data = fill_active ? fill_value_q : commit_data;

        // Port A writes and captures the old word for RMW; port B serves reads.
        always_ff @(posedge clk_i) begin
            if (bank_we) mem[bank_row] <= bank_data;
            if (rd_acc && (rd_bank == BANK_BITS'(b))) rd_q <= mem[rd_row];
            if (part_wr && (wr_bank == BANK_BITS'(b))) old_q <= mem[wr_row];
        end

        assign bank_rd[b]  = rd_q;
        assign bank_old[b] = old_q;
    end

    assign rd_data_o = rd_bypass_q ? rd_bypass_data_q : bank_rd[rd_bank_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            fill_row_q    <= '0;
            rmw_pending_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rd_valid_q    <= rd_acc;
            rmw_pending_q <= part_wr;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state_q    <= ST_FILL;
                        fill_row_q <= '0;
                    end
                end
                default: begin
                    fill_row_q <= fill_row_q + ROW_W'(1);
                    if (fill_last) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload registers need no reset; they are only consumed under a reset-cleared qualifier.
    always_ff @(posedge clk_i) begin
        if (clr_acc) fill_value_q <= clr_value_i;
        if (part_wr) begin
            rmw_addr_q  <= wr_addr_i;
            rmw_value_q <= wr_value_i;
            rmw_mask_q  <= wr_mask_i;
        end
        if (rd_acc) begin
            rd_bank_q        <= rd_bank;
            rd_bypass_q      <= commit_en && (commit_addr == rd_addr_i);
            rd_bypass_data_q <= commit_data;
        end
    end

endmodule

// File: tb/tb_gpu_stencil_bank_array.sv
// Randomized self-checking bench for gpu_stencil_bank_array against an array-based memory model.
module tb_gpu_stencil_bank_array;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd_req, rd_ready, rd_valid, wr_req, wr_ready;
    logic [14:0] rd_addr, wr_addr;
    logic [15:0] rd_data, wr_mask, wr_value, clr_value;
    logic        clr_req, clr_busy, clr_done, err_clr, err;

    logic        p_rd_req, p_rd_ready, p_rd_valid, p_wr_req, p_wr_ready;
    logic [9:0]  p_rd_addr, p_wr_addr;
    logic [15:0] p_rd_data, p_wr_mask, p_wr_value, p_clr_value;
    logic        p_clr_req, p_clr_busy, p_clr_done, p_err_clr, p_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_mem   [32768];
    logic [15:0] p_ref_mem [1024];

    gpu_stencil_bank_array dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_mask_i(wr_mask),
        .wr_value_i(wr_value), .wr_ready_o(wr_ready),
        .clr_req_i(clr_req), .clr_value_i(clr_value), .clr_busy_o(clr_busy),
        .clr_done_o(clr_done), .err_clr_i(err_clr), .err_o(err)
    );

    gpu_stencil_bank_array #(.DATA_W(16), .ADDR_W(10), .BANK_BITS(2)) dut_p (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_req_i(p_rd_req), .rd_addr_i(p_rd_addr), .rd_ready_o(p_rd_ready),
        .rd_valid_o(p_rd_valid), .rd_data_o(p_rd_data),
        .wr_req_i(p_wr_req), .wr_addr_i(p_wr_addr), .wr_mask_i(p_wr_mask),
        .wr_value_i(p_wr_value), .wr_ready_o(p_wr_ready),
        .clr_req_i(p_clr_req), .clr_value_i(p_clr_value), .clr_busy_o(p_clr_busy),
        .clr_done_o(p_clr_done), .err_clr_i(p_err_clr), .err_o(p_err)
    );

    task automatic idle_inputs();
        rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_mask = '0; wr_value = '0;
        clr_req = 0; clr_value = '0; err_clr = 0;
        p_rd_req = 0; p_rd_addr = '0; p_wr_req = 0; p_wr_addr = '0; p_wr_mask = '0;
        p_wr_value = '0; p_clr_req = 0; p_clr_value = '0; p_err_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill the main instance and count the busy/done cycles; returns the counts.
    task automatic run_fill(input logic [15:0] value, output int busy_cnt, output int done_cnt);
        clr_req = 1; clr_value = value;
        tick();
        clr_req = 0; clr_value = 16'($urandom);
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            if (!clr_busy) break;
            busy_cnt++;
            if (clr_done) done_cnt++;
            tick();
        end
        for (int i = 0; i < 32768; i++) ref_mem[i] = value;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b done=%b err=%b want 0 0 0 0",
                     rd_valid, clr_busy, clr_done, err);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        checks++;
        if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got rd=%b wr=%b want 1 1", rd_ready, wr_ready);
        end
    endtask

    task automatic test_fill();
        int busy_cnt, done_cnt;
        logic [14:0] addrs [3];
        clr_req = 1; clr_value = 16'h00FF;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_wr_ready_on_clr got %b want 0", wr_ready);
        end
        tick();
        clr_req = 0; clr_value = 16'h1111;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            if (!clr_busy) break;
            busy_cnt++;
            if (clr_done) done_cnt++;
            rd_req = (c == 10); rd_addr = 15'h0005;
            err_clr = (c == 12);
            clr_req = (c == 20); clr_value = 16'hDEAD;
            if (c == 10) begin
                checks++;
                if (rd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_rd_ready got %b want 0", rd_ready);
                end
            end
            if (c == 11) begin
                checks++;
                if (err !== 1'b1 || rd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_read_err got err=%b valid=%b want 1 0", err, rd_valid);
                end
            end
            if (c == 13 || c == 21) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_err_cleared cyc=%0d got %b want 0", c, err);
                end
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (busy_cnt != 4096 || done_cnt != 1) begin
            errors++;
            $display("FAIL fill_cycles got busy=%0d done=%0d want 4096 1", busy_cnt, done_cnt);
        end
        for (int i = 0; i < 32768; i++) ref_mem[i] = 16'h00FF;
        addrs[0] = 15'h0000; addrs[1] = 15'h3FFF; addrs[2] = 15'h7FFF;
        for (int i = 0; i < 3; i++) begin
            rd_req = 1; rd_addr = addrs[i];
            tick();
            rd_req = 0;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== ref_mem[addrs[i]]) begin
                errors++;
                $display("FAIL fill_readback addr=%h got valid=%b data=%h want 1 %h",
                         addrs[i], rd_valid, rd_data, ref_mem[addrs[i]]);
            end
        end
    endtask

    task automatic test_full_write();
        wr_req = 1; wr_addr = 15'h0009; wr_mask = 16'hFFFF; wr_value = 16'h1234;
        rd_req = 1; rd_addr = 15'h0009;
        tick();
        idle_inputs();
        ref_mem[9] = 16'h1234;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
            errors++;
            $display("FAIL full_write_bypass got valid=%b data=%h want 1 1234", rd_valid, rd_data);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_idle got %b want 0", rd_valid);
        end
    endtask

    task automatic test_rmw();
        wr_req = 1; wr_addr = 15'h0042; wr_mask = 16'hFFFF; wr_value = 16'hAAAA;
        tick();
        wr_mask = 16'h00FF; wr_value = 16'h5555;
        rd_req = 1; rd_addr = 15'h0042;
        tick();
        wr_req = 0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hAAAA || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmw_old_word got valid=%b data=%h wr_ready=%b want 1 aaaa 0",
                     rd_valid, rd_data, wr_ready);
        end
        tick();
        rd_req = 0;
        ref_mem[15'h42] = 16'hAA55;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hAA55 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmw_merged got valid=%b data=%h wr_ready=%b want 1 aa55 1",
                     rd_valid, rd_data, wr_ready);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        wr_req = 1; wr_addr = 15'h0050; wr_mask = 16'hFF00; wr_value = 16'h1200;
        tick();
        wr_mask = 16'hFFFF; wr_value = 16'hFFFF;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err_early got %b want 0", err);
        end
        tick();
        wr_req = 0;
        rd_req = 1; rd_addr = 15'h0050;
        ref_mem[15'h50] = 16'h12FF;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL b2b_err_set got %b want 1", err);
        end
        tick();
        rd_req = 0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h12FF || err !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ram_unchanged got valid=%b data=%h err=%b want 1 12ff 1",
                     rd_valid, rd_data, err);
        end
        // Violation and clear in the same cycle: the set must win.
        wr_req = 1; wr_addr = 15'h0051; wr_mask = 16'h0F0F; wr_value = 16'hA5A5;
        err_clr = 1;
        tick();
        err_clr = 1; wr_mask = 16'hFFFF;
        tick();
        wr_req = 0; err_clr = 0;
        ref_mem[15'h51] = (16'hA5A5 & 16'h0F0F) | (16'h00FF & 16'hF0F0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set_priority got %b want 1", err);
        end
        err_clr = 1;
        tick();
        err_clr = 0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", err);
        end
    endtask

    task automatic test_random();
        logic        m_pend, m_err, exp_valid;
        logic [14:0] m_paddr;
        logic [15:0] m_pval, m_pmask, exp_data;
        m_pend = 0; m_err = 0; m_paddr = '0; m_pval = '0; m_pmask = '0;
        for (int c = 0; c < 1500; c++) begin
            rd_req = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 31));
            wr_req = 1'($urandom_range(0, 1));
            wr_addr = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 31));
            wr_mask = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            wr_value = 16'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (wr_ready !== !m_pend || rd_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_ready cyc=%0d got wr=%b rd=%b want %b 1",
                         c, wr_ready, rd_ready, !m_pend);
            end
            exp_valid = rd_req;
            if (m_pend) begin
                ref_mem[m_paddr] = (m_pval & m_pmask) | (ref_mem[m_paddr] & ~m_pmask);
                m_pend = 0;
                if (wr_req) m_err = 1;
                else if (err_clr) m_err = 0;
            end else begin
                if (wr_req && wr_mask == 16'hFFFF) ref_mem[wr_addr] = wr_value;
                if (wr_req && wr_mask != 16'hFFFF) begin
                    m_pend = 1; m_paddr = wr_addr; m_pval = wr_value; m_pmask = wr_mask;
                end
                if (err_clr) m_err = 0;
            end
            exp_data = ref_mem[rd_addr];
            tick();
            checks++;
            if (rd_valid !== exp_valid || (exp_valid && rd_data !== exp_data) || err !== m_err) begin
                errors++;
                $display("FAIL rand_read cyc=%0d got valid=%b data=%h err=%b want %b %h %b",
                         c, rd_valid, rd_data, err, exp_valid, exp_data, m_err);
            end
        end
        idle_inputs();
        if (m_pend) ref_mem[m_paddr] = (m_pval & m_pmask) | (ref_mem[m_paddr] & ~m_pmask);
        err_clr = 1;
        tick();
        err_clr = 0;
        for (int i = 0; i < 32; i++) begin
            rd_req = 1; rd_addr = 15'(i);
            tick();
            rd_req = 0;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== ref_mem[i]) begin
                errors++;
                $display("FAIL rand_sweep addr=%0d got valid=%b data=%h want 1 %h",
                         i, rd_valid, rd_data, ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int busy_cnt, done_cnt;
        clr_req = 1; clr_value = 16'h0F0F;
        tick();
        clr_req = 0;
        rd_req = 1; rd_addr = 15'h0001;
        tick();
        rd_req = 0;
        repeat (99) tick();
        checks++;
        if (err !== 1'b1 || clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL midfill_pre got err=%b busy=%b want 1 1", err, clr_busy);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || err !== 1'b0 || clr_done !== 1'b0 || rd_valid !== 1'b0 ||
            rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midfill_async_reset got busy=%b err=%b done=%b valid=%b rd_ready=%b want 0 0 0 0 1",
                     clr_busy, err, clr_done, rd_valid, rd_ready);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        run_fill(16'h3C3C, busy_cnt, done_cnt);
        checks++;
        if (busy_cnt != 4096 || done_cnt != 1) begin
            errors++;
            $display("FAIL refill_cycles got busy=%0d done=%0d want 4096 1", busy_cnt, done_cnt);
        end
        rd_req = 1; rd_addr = 15'h1234;
        tick();
        rd_addr = 15'h7FFF;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h3C3C) begin
            errors++;
            $display("FAIL refill_read0 got valid=%b data=%h want 1 3c3c", rd_valid, rd_data);
        end
        tick();
        rd_req = 0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h3C3C) begin
            errors++;
            $display("FAIL refill_read1 got valid=%b data=%h want 1 3c3c", rd_valid, rd_data);
        end
    endtask

    task automatic test_bank_parallel();
        int busy_cnt;
        logic [15:0] v;
        p_clr_req = 1; p_clr_value = 16'h0000;
        tick();
        p_clr_req = 0;
        busy_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p_clr_busy) break;
            busy_cnt++;
            tick();
        end
        for (int i = 0; i < 1024; i++) p_ref_mem[i] = 16'h0000;
        checks++;
        if (busy_cnt != 256) begin
            errors++;
            $display("FAIL par_fill_cycles got %0d want 256", busy_cnt);
        end
        p_wr_req = 1; p_wr_addr = 10'h001; p_wr_mask = 16'hFFFF; p_wr_value = 16'hBEEF;
        p_ref_mem[1] = 16'hBEEF;
        tick();
        for (int c = 0; c < 256; c++) begin
            v = 16'($urandom);
            p_rd_req = 1; p_rd_addr = 10'h001;
            p_wr_req = 1; p_wr_addr = 10'h002; p_wr_value = v;
            p_ref_mem[2] = v;
            tick();
            checks++;
            if (p_rd_valid !== 1'b1 || p_rd_data !== p_ref_mem[1]) begin
                errors++;
                $display("FAIL par_read cyc=%0d got valid=%b data=%h want 1 %h",
                         c, p_rd_valid, p_rd_data, p_ref_mem[1]);
            end
        end
        p_wr_req = 0; p_rd_addr = 10'h002;
        tick();
        p_rd_req = 0;
        checks++;
        if (p_rd_valid !== 1'b1 || p_rd_data !== p_ref_mem[2] || p_err !== 1'b0) begin
            errors++;
            $display("FAIL par_final got valid=%b data=%h err=%b want 1 %h 0",
                     p_rd_valid, p_rd_data, p_err, p_ref_mem[2]);
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_full_write();
        test_rmw();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
        test_bank_parallel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
